cios_final_sub: RTL and testbench
=================================

CIOS_FINAL_SUB -- requirements
Module: cios_final_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning word width in bits.
REQ-002 SHALL have parameter NWORDS, default 4, meaning number of result words per operand (s), minimum 2.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, in_word is valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts in_word this cycle.
REQ-007 SHALL have port in_word, input, WIDTH, T word from the CIOS array, LSW first; word NWORDS is the top carry word.
REQ-008 SHALL have port n_addr, output, $clog2(NWORDS), index of the modulus word required this cycle.
REQ-009 SHALL have port n_word, input, WIDTH, modulus word N[n_addr]; combinational, zero-latency read.
REQ-010 SHALL have port out_valid, output, 1, out_word is valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts out_word.
REQ-012 SHALL have port out_word, output, WIDTH, reduced result word, LSW first.
REQ-013 SHALL have port out_last, output, 1, marks the final result word (index NWORDS-1).
REQ-014 SHALL have port ovf, output, 1, top-word bound violation flag (see Configuration).

Function
REQ-015 SHALL implement FSM states COLLECT and EMIT; transfers occur only on valid&&ready.
REQ-016 In COLLECT, in_ready SHALL be 1 and out_valid 0; in EMIT, in_ready SHALL be 0.
REQ-017 In COLLECT, a word counter i (0..NWORDS) SHALL count accepted words; n_addr SHALL equal i for i<NWORDS, and 0 otherwise.
REQ-018 On accepting word i<NWORDS: store t[i]=in_word; store d[i]=(in_word-n_word-borrow) mod 2^WIDTH; update borrow to the borrow-out of that subtraction; borrow SHALL be 0 at i=0.
REQ-019 On accepting word i=NWORDS (top): latch sel=(in_word!=0)||(borrow==0); transition to EMIT; reset i and borrow to 0.
REQ-020 In EMIT, out_valid SHALL be 1 and out_word SHALL equal d[j] if sel else t[j], for output counter j starting at 0.
REQ-021 out_word, out_last and out_valid SHALL be held stable while out_valid&&!out_ready.
REQ-022 out_last SHALL be 1 only when j==NWORDS-1; on that transfer, the FSM SHALL return to COLLECT next cycle, and j SHALL be reset to 0.
REQ-023 Latency: the first out_word SHALL be valid the cycle after the top word is accepted; throughput is one word per cycle with no stalls.
REQ-024 Result SHALL equal (top*2^(WIDTH*NWORDS)+T) - N when that value is >=0, else T; only the low NWORDS words are output.
REQ-025 Gaps in in_valid SHALL NOT alter stored words, borrow or counter.

Reset
REQ-026 On rst, state SHALL be COLLECT; i, j, borrow, sel, all t[]/d[] storage, out_valid, out_last, out_word and ovf SHALL be 0; in_ready SHALL be 1 the first cycle after rst deasserts.
REQ-027 rst asserted mid-COLLECT or mid-EMIT SHALL discard the partial operand/result; no word of it SHALL be emitted afterward.

Configuration
REQ-028 Macro CIOS_TOPCHK_EN: when defined, ovf SHALL be latched to (top word > 1) when the top word is accepted, and held through EMIT until the out_last transfer, then cleared.
REQ-029 Without CIOS_TOPCHK_EN, ovf SHALL be constant 0 and no comparator logic SHALL be built; all other behaviour is identical.

Verification (WIDTH=8, NWORDS=2, N words {0x05,0x01} = 0x0105)
REQ-030 In {0x03,0x01}, top 0x00 (T<N) -> out 0x03, 0x01; out_last on 2nd word.
REQ-031 In {0x07,0x01}, top 0x00 -> out 0x02, 0x00.
REQ-032 In {0x05,0x01}, top 0x00 (T==N) -> out 0x00, 0x00.
REQ-033 In {0x00,0x00}, top 0x01 -> out 0xFB, 0xFE; ovf 0; with CIOS_TOPCHK_EN and top 0x02 -> ovf 1 through out_last.
REQ-034 Back-to-back operands with out_ready low 3 cycles on word 0 -> out_word held at word 0, in_ready 0 throughout EMIT, next operand accepted the cycle after out_last transfer.
REQ-035 rst pulsed after one word accepted, then a full operand {0x07,0x01}, top 0x00 -> only 0x02, 0x00 emitted.

Source files
------------

// File: rtl/cios_final_sub.sv
// cios_final_sub
//   Final conditional subtraction stage of a word-serial CIOS Montgomery
//   multiplier. Collects the NWORDS+1 word result T (LSW first, the last
//   word being the top carry word), computes T-N word by word as the words
//   arrive, then streams out either T-N or T (LSW first) depending on
//   whether the subtraction underflowed.
//
//   Optional feature macro: CIOS_TOPCHK_EN
//     defined   : ovf flags a top carry word greater than 1, held from
//                 top-word acceptance through the out_last transfer.
//     undefined : ovf is tied to 0 and no comparator is built.
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   in_valid  : in_word is valid
//   in_ready  : block accepts in_word this cycle (high while collecting)
//   in_word   : T word, LSW first; word NWORDS is the top carry word
//   n_addr    : index of the modulus word needed this cycle
//   n_word    : modulus word N[n_addr], combinational read
//   out_valid : out_word is valid
//   out_ready : downstream accepts out_word
//   out_word  : reduced result word, LSW first
//   out_last  : marks result word NWORDS-1
//   ovf       : top-word bound violation flag (see macro above)

module cios_final_sub #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_word,
  output logic [$clog2(NWORDS)-1:0] n_addr,
  input  logic [WIDTH-1:0]          n_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_word,
  output logic                      out_last,
  output logic                      ovf
);

  localparam int AW = $clog2(NWORDS);
  localparam int CW = $clog2(NWORDS + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CW-1:0]    r_i;
  logic [AW-1:0]    r_j;
  logic             r_borrow;
  logic             r_sel;
  logic [WIDTH-1:0] r_t [NWORDS];
  logic [WIDTH-1:0] r_d [NWORDS];

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_top;
  logic             w_last;
  logic [AW-1:0]    w_idx;
  logic [WIDTH:0]   w_diff;

  // Word NWORDS is the top carry word; it carries no modulus word.
  assign w_top  = (r_i == CW'(NWORDS));
  assign w_idx  = r_i[AW-1:0];
  assign w_last = (r_j == AW'(NWORDS - 1));
  assign n_addr = w_top ? '0 : w_idx;

  // One extra bit captures the borrow-out of the running subtraction.
  assign w_diff = {1'b0, in_word} - {1'b0, n_word} - {{WIDTH{1'b0}}, r_borrow};

  assign w_in_fire  = in_valid  && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && w_top) begin
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && w_last) begin
          w_state_nxt = COLLECT;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  // Output word is driven only while emitting so it reads 0 elsewhere.
  always_comb begin
    out_word = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_word = r_sel ? r_d[r_j] : r_t[r_j];
      out_last = w_last;
    end
  end

  // Collect side: store T, T-N and the running borrow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i      <= '0;
      r_borrow <= 1'b0;
      r_sel    <= 1'b0;
      for (int unsigned k = 0; k < NWORDS; k++) begin
        r_t[k] <= '0;
        r_d[k] <= '0;
      end
    end else if (w_in_fire) begin
      if (w_top) begin
        // A nonzero top word means top*2^(WIDTH*NWORDS)+T already exceeds N;
        // otherwise the result is non-negative exactly when no borrow remains.
        r_sel    <= (in_word != '0) || !r_borrow;
        r_i      <= '0;
        r_borrow <= 1'b0;
      end else begin
        r_t[w_idx] <= in_word;
        r_d[w_idx] <= w_diff[WIDTH-1:0];
        r_borrow   <= w_diff[WIDTH];
        r_i        <= r_i + CW'(1);
      end
    end
  end

  // Emit side: output word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_j <= '0;
    end else if (w_out_fire) begin
      r_j <= w_last ? '0 : r_j + AW'(1);
    end
  end

`ifdef CIOS_TOPCHK_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_in_fire && w_top) begin
      r_ovf <= (in_word > WIDTH'(1));
    end else if (w_out_fire && w_last) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cios_final_sub.sv
module tb_cios_final_sub;

  localparam int W  = 8;
  localparam int NW = 2;
  localparam int AW = $clog2(NW);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_word;
  logic [AW-1:0] n_addr;
  logic [W-1:0]  n_word;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_word;
  logic          out_last;
  logic          ovf;

  logic [W-1:0]  n_mem [NW];
  assign n_word = n_mem[n_addr];

  cios_final_sub #(.WIDTH(W), .NWORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .n_addr    (n_addr),
    .n_word    (n_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: full value top*2^(W*NW)+T minus N if non-negative, else T.
  function automatic logic [NW*W-1:0] ref_result(input logic [NW*W-1:0] t,
                                                 input logic [W-1:0] top,
                                                 input logic [NW*W-1:0] n);
    logic [NW*W+W-1:0] full;
    logic [NW*W+W-1:0] diff;
    full = {top, t};
    if (full >= {{W{1'b0}}, n}) begin
      diff = full - {{W{1'b0}}, n};
      return diff[NW*W-1:0];
    end
    return t;
  endfunction

  function automatic logic [NW*W-1:0] n_value();
    logic [NW*W-1:0] v;
    for (int k = 0; k < NW; k++) v[k*W +: W] = n_mem[k];
    return v;
  endfunction

  typedef struct {
    logic [W-1:0] w;
    logic         last;
    logic         ovf;
  } exp_t;

  exp_t           q[$];
  logic           m_emit = 1'b0;
  int             m_cnt  = 0;
  logic [W-1:0]   m_buf [NW+1];

  // Single compare process: checks outputs against the model on every
  // falling edge, then advances the model for the coming rising edge.
  always @(negedge clk) begin
    logic            emit_now;
    logic [NW*W-1:0] t;
    logic [NW*W-1:0] r;
    logic            o;
    if (rst) begin
      chk("rst_in_ready",  in_ready,  1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_word",  out_word,  '0);
      chk("rst_out_last",  out_last,  1'b0);
      chk("rst_ovf",       ovf,       1'b0);
      q.delete();
      m_emit = 1'b0;
      m_cnt  = 0;
    end else begin
      emit_now = m_emit;
      chk("in_ready",  in_ready,  !emit_now);
      chk("out_valid", out_valid, emit_now);
      if (!emit_now) begin
        chk("n_addr",   n_addr,   (m_cnt < NW) ? m_cnt : 0);
        chk("out_last", out_last, 1'b0);
        chk("ovf_idle", ovf,      1'b0);
      end else if (q.size() == 0) begin
        chk("model_queue_nonempty", 0, 1);
      end else begin
        chk("out_word", out_word, q[0].w);
        chk("out_last", out_last, q[0].last);
        chk("ovf",      ovf,      q[0].ovf);
      end
      if (!emit_now && in_valid) begin
        m_buf[m_cnt] = in_word;
        if (m_cnt == NW) begin
          for (int k = 0; k < NW; k++) t[k*W +: W] = m_buf[k];
          r = ref_result(t, m_buf[NW], n_value());
`ifdef CIOS_TOPCHK_EN
          o = (m_buf[NW] > 1);
`else
          o = 1'b0;
`endif
          for (int k = 0; k < NW; k++) q.push_back('{r[k*W +: W], (k == NW-1), o});
          m_emit = 1'b1;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
      if (emit_now && out_ready && q.size() != 0) begin
        if (q[0].last) m_emit = 1'b0;
        void'(q.pop_front());
      end
    end
  end

  // Downstream ready: forced stalls take priority, else random or always-on.
  int   stall_cnt  = 0;
  logic rand_ready = 1'b0;
  initial out_ready = 1'b1;
  always begin
    @(posedge clk);
    #2;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = rand_ready ? (($urandom % 3) != 0) : 1'b1;
    end
  end

  task automatic send_word(input logic [W-1:0] w);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_word  = W'($urandom);
  endtask

  task automatic send_op(input logic [NW*W-1:0] t, input logic [W-1:0] top, input int gaps);
    for (int k = 0; k <= NW; k++) begin
      if (gaps > 0) repeat ($urandom % (gaps + 1)) @(posedge clk);
      #0;
      send_word((k == NW) ? top : t[k*W +: W]);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!m_emit && q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NW*W-1:0] t;
    logic [W-1:0]    top;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_word  = '0;
    n_mem[0] = 8'h05;
    n_mem[1] = 8'h01;

    // Hand-computed pins of the reference model, N = 0x0105.
    chk("pin_t_lt_n", ref_result(16'h0103, 8'h00, 16'h0105), 16'h0103);
    chk("pin_t_gt_n", ref_result(16'h0107, 8'h00, 16'h0105), 16'h0002);
    chk("pin_t_eq_n", ref_result(16'h0105, 8'h00, 16'h0105), 16'h0000);
    chk("pin_top1",   ref_result(16'h0000, 8'h01, 16'h0105), 16'hFEFB);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors (N = 0x0105), words packed as {w1, w0}.
    send_op(16'h0103, 8'h00, 0);
    send_op(16'h0107, 8'h00, 0);
    send_op(16'h0105, 8'h00, 0);
    send_op(16'h0000, 8'h01, 0);
    send_op(16'h0000, 8'h02, 0);
    drain();

    // Stall on word 0 for three cycles, then a back-to-back operand.
    send_op(16'h0107, 8'h00, 0);
    stall_cnt = 3;
    send_op(16'h0103, 8'h00, 0);
    drain();

    // Reset after one accepted word, then a full operand.
    send_word(8'h07);
    reset_pulse();
    send_op(16'h0107, 8'h00, 0);
    drain();

    // Randomized traffic with random N, gaps, backpressure and resets.
    rand_ready = 1'b1;
    for (int op = 0; op < 300; op++) begin
      if (($urandom % 10) == 0) begin
        drain();
        for (int k = 0; k < NW; k++) n_mem[k] = W'($urandom);
      end
      case ($urandom % 4)
        0:       t = n_value() + NW*W'($urandom_range(0, 2)) - NW*W'($urandom_range(0, 2));
        default: t = NW*W'($urandom);
      endcase
      case ($urandom % 8)
        0:       top = W'($urandom);
        1, 2:    top = 8'h01;
        default: top = 8'h00;
      endcase
      if (($urandom % 25) == 0) begin
        send_word(t[W-1:0]);
        reset_pulse();
      end else begin
        send_op(t, top, 2);
        if (($urandom % 25) == 0) reset_pulse();
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
